aibndaux_actred_ctrl: RTL and testbench

Parametrised active-redundancy aux receive controller for NCHAIN redundancy chains. It takes the raw pad-receiver outputs of the actred chains and synchronises them. It debounces each chain, sequences per-chain receiver enables on chain bring-up, applies redundancy shift (chain i repaired by chain i+1), and counts rejected glitches. It sits between the aux actred buffer instances and the digital adapter; it generalises the fixed two-chain, unfiltered actred path.

---
 rtl/aibndaux_actred_ctrl_pkg.sv | 22 ++
 rtl/aibndaux_actred_ctrl_if.sv | 35 +++
 rtl/aibndaux_actred_chfilt.sv | 117 +++++++++++
 rtl/aibndaux_actred_ctrl.sv | 78 +++++++
 tb/tb_aibndaux_actred_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aibndaux_actred_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aibndaux_actred_pkg
// Shared types and constants for the active-redundancy aux receive controller:
//   - chain_state_t : per-chain bring-up / tracking state
//   - *_DEF         : default debounce, settle and glitch-counter sizing
//   - RXEN_OFF      : receiver enable code that powers a pad buffer down
// -----------------------------------------------------------------------------
package aibndaux_actred_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_TRACK  = 2'd2
   } chain_state_t;

   localparam int unsigned FILT_CNT_DEF   = 8;
   localparam int unsigned SETTLE_CYC_DEF = 16;
   localparam int unsigned GCNT_W_DEF     = 8;

   localparam logic [2:0] RXEN_OFF = 3'b000;

endpackage

// File: rtl/aibndaux_actred_ctrl_if.sv
// -----------------------------------------------------------------------------
// aibndaux_actred_ctrl_if
// Bundles the controller's chain data, control and status signals.
//   master : adapter side, drives raw data / enables / config, reads status
//   slave  : controller side
// Signals: actred_raw, chain_en, rxen_cfg, shiften, clr_stat (to controller);
//          rxen_out, actred_out, chain_rdy, glitch_cnt, shift_fault (from it).
// -----------------------------------------------------------------------------
interface aibndaux_actred_ctrl_if
   import aibndaux_actred_pkg::*;
#(
   parameter int NCHAIN = 2,
   parameter int GCNT_W = GCNT_W_DEF
);
   logic [NCHAIN-1:0]        actred_raw;
   logic [NCHAIN-1:0]        chain_en;
   logic [3*NCHAIN-1:0]      rxen_cfg;
   logic [NCHAIN-1:0]        shiften;
   logic                     clr_stat;
   logic [3*NCHAIN-1:0]      rxen_out;
   logic [NCHAIN-1:0]        actred_out;
   logic [NCHAIN-1:0]        chain_rdy;
   logic [GCNT_W*NCHAIN-1:0] glitch_cnt;
   logic                     shift_fault;

   modport master (
      output actred_raw, chain_en, rxen_cfg, shiften, clr_stat,
      input  rxen_out, actred_out, chain_rdy, glitch_cnt, shift_fault
   );

   modport slave (
      input  actred_raw, chain_en, rxen_cfg, shiften, clr_stat,
      output rxen_out, actred_out, chain_rdy, glitch_cnt, shift_fault
   );
endinterface

// File: rtl/aibndaux_actred_chfilt.sv
// -----------------------------------------------------------------------------
// aibndaux_actred_chfilt
// One actred chain: synchroniser, IDLE/SETTLE/TRACK bring-up FSM, debounce
// filter and saturating rejected-glitch counter.
// Ports:
//   clk, rst     : clock, async active-high reset
//   i_raw        : raw pad receiver bit (asynchronous)
//   i_en         : chain enable level
//   i_rxen_cfg   : receiver enable code used while the chain is up
//   i_clr_stat   : clear the glitch counter
//   o_rxen       : receiver enable to the pad buffer
//   o_filt       : debounced chain level
//   o_rdy        : chain is in TRACK
//   o_gcnt       : rejected-glitch count
// -----------------------------------------------------------------------------
module aibndaux_actred_chfilt
   import aibndaux_actred_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CNT    = FILT_CNT_DEF,
   parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter int GCNT_W      = GCNT_W_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_raw,
   input  logic              i_en,
   input  logic [2:0]        i_rxen_cfg,
   input  logic              i_clr_stat,
   output logic [2:0]        o_rxen,
   output logic              o_filt,
   output logic              o_rdy,
   output logic [GCNT_W-1:0] o_gcnt
);

   localparam logic [7:0] SCNT_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] DCNT_LAST = 8'(FILT_CNT - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   chain_state_t           r_state;
   logic [7:0]             r_scnt;
   logic [7:0]             r_dcnt;
   logic                   r_filt;
   logic [GCNT_W-1:0]      r_gcnt;
   logic                   w_s;
   logic                   w_glitch;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   // A run of differing samples that ends before reaching the threshold.
   assign w_glitch = i_en && (r_state == ST_TRACK) && (w_s == r_filt) && (r_dcnt != 8'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_scnt  <= 8'd0;
         r_dcnt  <= 8'd0;
         r_filt  <= 1'b0;
      end else if (!i_en) begin
         r_state <= ST_IDLE;
         r_scnt  <= 8'd0;
         r_dcnt  <= 8'd0;
         r_filt  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_SETTLE;
               r_scnt  <= 8'd0;
            end
            ST_SETTLE: begin
               if (r_scnt == SCNT_LAST) begin
                  // Receiver has settled: take its level directly, no debounce.
                  r_state <= ST_TRACK;
                  r_filt  <= w_s;
                  r_dcnt  <= 8'd0;
               end else begin
                  r_scnt <= r_scnt + 8'd1;
               end
            end
            ST_TRACK: begin
               if (w_s != r_filt) begin
                  if (r_dcnt == DCNT_LAST) begin
                     r_filt <= w_s;
                     r_dcnt <= 8'd0;
                  end else begin
                     r_dcnt <= r_dcnt + 8'd1;
                  end
               end else if (r_dcnt != 8'd0) begin
                  r_dcnt <= 8'd0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Survives chain disable; only reset or clr_stat zero it. Clear beats count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         r_gcnt <= '0;
      else if (i_clr_stat)             r_gcnt <= '0;
      else if (w_glitch && ~&r_gcnt)   r_gcnt <= r_gcnt + 1'b1;
   end

   // Enable code follows config live once the chain has left IDLE.
   assign o_rxen = (r_state == ST_IDLE) ? RXEN_OFF : i_rxen_cfg;
   assign o_filt = r_filt;
   assign o_rdy  = (r_state == ST_TRACK);
   assign o_gcnt = r_gcnt;

endmodule

// File: rtl/aibndaux_actred_ctrl.sv
// -----------------------------------------------------------------------------
// aibndaux_actred_ctrl
// Active-redundancy aux receive controller for NCHAIN chains. Each chain is
// synchronised, sequenced and debounced in aibndaux_actred_chfilt; this level
// applies the registered redundancy shift (chain i+1 repairs chain i) and
// keeps the sticky shift_fault for a shift request on the top chain.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : aibndaux_actred_ctrl_if slave modport (all data/control/status)
// -----------------------------------------------------------------------------
module aibndaux_actred_ctrl
   import aibndaux_actred_pkg::*;
#(
   parameter int NCHAIN      = 2,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CNT    = FILT_CNT_DEF,
   parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter int GCNT_W      = GCNT_W_DEF
)(
   input  logic                  clk,
   input  logic                  rst,
   aibndaux_actred_ctrl_if.slave bus
);

   logic [NCHAIN-1:0][2:0]        w_rxen;
   logic [NCHAIN-1:0][GCNT_W-1:0] w_gcnt;
   logic [NCHAIN-1:0]             w_filt;
   logic [NCHAIN-1:0]             w_rdy;
   logic [NCHAIN-1:0]             w_filtm;
   logic [NCHAIN-1:0]             w_up;
   logic [NCHAIN-1:0]             w_map;
   logic [NCHAIN-1:0]             r_out;
   logic                          r_fault;

   for (genvar g = 0; g < NCHAIN; g++) begin : g_chain
      aibndaux_actred_chfilt #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_CNT    (FILT_CNT),
         .SETTLE_CYC  (SETTLE_CYC),
         .GCNT_W      (GCNT_W)
      ) u_chfilt (
         .clk        (clk),
         .rst        (rst),
         .i_raw      (bus.actred_raw[g]),
         .i_en       (bus.chain_en[g]),
         .i_rxen_cfg (bus.rxen_cfg[3*g +: 3]),
         .i_clr_stat (bus.clr_stat),
         .o_rxen     (w_rxen[g]),
         .o_filt     (w_filt[g]),
         .o_rdy      (w_rdy[g]),
         .o_gcnt     (w_gcnt[g])
      );
   end

   // Chains not yet tracking contribute 0 to the map.
   assign w_filtm = w_filt & w_rdy;
   // Spare for chain i is chain i+1; the top chain has no spare, so it sees 0.
   assign w_up    = {1'b0, w_filtm[NCHAIN-1:1]};
   assign w_map   = (w_up & bus.shiften) | (w_filtm & ~bus.shiften);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out   <= '0;
         r_fault <= 1'b0;
      end else begin
         r_out <= w_map;
         if (bus.clr_stat)                r_fault <= 1'b0;
         else if (bus.shiften[NCHAIN-1])  r_fault <= 1'b1;
      end
   end

   assign bus.rxen_out    = w_rxen;
   assign bus.glitch_cnt  = w_gcnt;
   assign bus.chain_rdy   = w_rdy;
   assign bus.actred_out  = r_out;
   assign bus.shift_fault = r_fault;

endmodule

// File: tb/tb_aibndaux_actred_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aibndaux_actred_ctrl
// Directed bring-up / debounce / saturation / redundancy / disable / reset
// sequence followed by a randomized phase. Every cycle is also compared with a
// behavioural model: synchroniser as a sample queue, bring-up as cycles since
// enable, debounce as the length of the current disagreeing run.
// -----------------------------------------------------------------------------
module tb_aibndaux_actred_ctrl;
   import aibndaux_actred_pkg::*;

   localparam int NCHAIN = 2;
   localparam int SS     = 2;
   localparam int FC     = 8;
   localparam int SC     = 16;
   localparam int GW     = 8;
   localparam int RW     = 3 * NCHAIN;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aibndaux_actred_ctrl_if #(.NCHAIN(NCHAIN), .GCNT_W(GW)) bus ();

   aibndaux_actred_ctrl #(
      .NCHAIN      (NCHAIN),
      .SYNC_STAGES (SS),
      .FILT_CNT    (FC),
      .SETTLE_CYC  (SC),
      .GCNT_W      (GW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   bit                m_pipe [NCHAIN][$];
   int                m_age  [NCHAIN];   // 0 = off, 1..SC settling, SC+1 tracking
   int                m_run  [NCHAIN];
   int                m_gcnt [NCHAIN];
   bit                m_filt [NCHAIN];
   bit [NCHAIN-1:0]   m_out;
   bit                m_fault;

   function automatic void model_reset();
      for (int c = 0; c < NCHAIN; c++) begin
         m_pipe[c] = {};
         for (int k = 0; k < SS; k++) m_pipe[c].push_back(1'b0);
         m_age[c]  = 0;
         m_run[c]  = 0;
         m_gcnt[c] = 0;
         m_filt[c] = 1'b0;
      end
      m_out   = '0;
      m_fault = 1'b0;
   endfunction

   function automatic void model_edge();
      bit [NCHAIN-1:0] fm;
      bit s;
      bit glitch;
      for (int c = 0; c < NCHAIN; c++) fm[c] = m_filt[c] && (m_age[c] > SC);
      m_out = ((fm >> 1) & bus.shiften) | (fm & ~bus.shiften);
      if (bus.clr_stat)               m_fault = 1'b0;
      else if (bus.shiften[NCHAIN-1]) m_fault = 1'b1;
      for (int c = 0; c < NCHAIN; c++) begin
         s = m_pipe[c].pop_front();
         m_pipe[c].push_back(bus.actred_raw[c]);
         glitch = 1'b0;
         if (!bus.chain_en[c]) begin
            m_age[c] = 0; m_run[c] = 0; m_filt[c] = 1'b0;
         end else if (m_age[c] < SC) begin
            m_age[c]++;
         end else if (m_age[c] == SC) begin
            m_age[c] = SC + 1; m_filt[c] = s; m_run[c] = 0;
         end else if (s != m_filt[c]) begin
            if (m_run[c] == FC - 1) begin m_filt[c] = s; m_run[c] = 0; end
            else m_run[c]++;
         end else if (m_run[c] != 0) begin
            m_run[c] = 0; glitch = 1'b1;
         end
         if (bus.clr_stat) m_gcnt[c] = 0;
         else if (glitch && m_gcnt[c] < (1 << GW) - 1) m_gcnt[c]++;
      end
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [RW-1:0]        er;
      logic [NCHAIN-1:0]    erdy;
      logic [GW*NCHAIN-1:0] eg;
      for (int c = 0; c < NCHAIN; c++) begin
         er[3*c +: 3]  = (m_age[c] > 0) ? bus.rxen_cfg[3*c +: 3] : 3'b000;
         erdy[c]       = (m_age[c] > SC);
         eg[GW*c +: GW] = GW'(m_gcnt[c]);
      end
      check({tag, ".rxen"},  64'(bus.rxen_out),    64'(er));
      check({tag, ".out"},   64'(bus.actred_out),  64'(m_out));
      check({tag, ".rdy"},   64'(bus.chain_rdy),   64'(erdy));
      check({tag, ".gcnt"},  64'(bus.glitch_cnt),  64'(eg));
      check({tag, ".fault"}, 64'(bus.shift_fault), 64'(m_fault));
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".rxen"},  64'(bus.rxen_out),    64'd0);
      check({tag, ".out"},   64'(bus.actred_out),  64'd0);
      check({tag, ".rdy"},   64'(bus.chain_rdy),   64'd0);
      check({tag, ".gcnt"},  64'(bus.glitch_cnt),  64'd0);
      check({tag, ".fault"}, 64'(bus.shift_fault), 64'd0);
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all("model");
   endtask

   // Two-cycle low pulse on chain 0 (which idles high); optional clr_stat on
   // the edge where the resulting glitch is recognised.
   task automatic glitch0(input bit with_clr);
      bus.actred_raw[0] = 1'b0;
      tick(); tick();
      bus.actred_raw[0] = 1'b1;
      tick(); tick();
      bus.clr_stat = with_clr;
      tick();
      bus.clr_stat = 1'b0;
      tick(); tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst            = 1'b1;
      bus.actred_raw = '0;
      bus.chain_en   = '0;
      bus.rxen_cfg   = '0;
      bus.shiften    = '0;
      bus.clr_stat   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_zero("reset");

      // Bring-up
      rst            = 1'b0;
      bus.chain_en   = 2'b11;
      bus.rxen_cfg   = 6'b101_011;
      bus.actred_raw = 2'b10;
      tick();
      check("bringup.rxen", 64'(bus.rxen_out), 64'h2B);
      check("bringup.rdy_early", 64'(bus.chain_rdy), 64'd0);
      repeat (15) tick();
      check("bringup.rdy_16", 64'(bus.chain_rdy), 64'd0);
      tick();
      check("bringup.rdy_17", 64'(bus.chain_rdy), 64'd3);
      tick();
      check("bringup.out", 64'(bus.actred_out), 64'd2);

      // Debounce latency
      bus.actred_raw = 2'b11;
      repeat (10) tick();
      check("deb.out_10", 64'(bus.actred_out[0]), 64'd0);
      tick();
      check("deb.out_11", 64'(bus.actred_out[0]), 64'd1);

      // 5-cycle pulse is rejected and counted once
      bus.actred_raw[0] = 1'b0;
      repeat (5) tick();
      bus.actred_raw[0] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("pulse.out", 64'(bus.actred_out[0]), 64'd1);
      end
      check("pulse.gcnt", 64'(bus.glitch_cnt[GW-1:0]), 64'd1);

      // Saturation, then clear coincident with a glitch
      for (int i = 0; i < 300; i++) glitch0(1'b0);
      check("sat.gcnt", 64'(bus.glitch_cnt[GW-1:0]), 64'd255);
      glitch0(1'b1);
      check("clr_sat.gcnt", 64'(bus.glitch_cnt[GW-1:0]), 64'd0);
      glitch0(1'b0);
      check("one.gcnt", 64'(bus.glitch_cnt[GW-1:0]), 64'd1);
      glitch0(1'b1);
      check("clr_one.gcnt", 64'(bus.glitch_cnt[GW-1:0]), 64'd0);

      // Redundancy map
      bus.actred_raw = 2'b10;
      repeat (14) tick();
      check("red.base", 64'(bus.actred_out), 64'd2);
      bus.shiften = 2'b01;
      tick();
      check("red.shift0", 64'(bus.actred_out), 64'd3);
      bus.shiften = 2'b10;
      tick();
      check("red.shift1.out", 64'(bus.actred_out), 64'd0);
      check("red.shift1.fault", 64'(bus.shift_fault), 64'd1);
      repeat (3) tick();
      bus.shiften = 2'b00;
      tick();
      check("red.sticky", 64'(bus.shift_fault), 64'd1);
      check("red.unshift", 64'(bus.actred_out), 64'd2);
      bus.clr_stat = 1'b1;
      tick();
      bus.clr_stat = 1'b0;
      check("red.clr", 64'(bus.shift_fault), 64'd0);

      // Disable chain 1 while it is debouncing
      bus.actred_raw = 2'b00;
      repeat (4) tick();
      bus.chain_en = 2'b01;
      tick();
      check("dis.rxen", 64'(bus.rxen_out), 64'h03);
      check("dis.rdy", 64'(bus.chain_rdy), 64'd1);
      tick();
      check("dis.out1", 64'(bus.actred_out[1]), 64'd0);

      // Async reset in the middle of chain 1 settling
      bus.chain_en = 2'b11;
      bus.shiften  = 2'b10;
      repeat (5) tick();
      check("pre_rst.rxen", 64'(bus.rxen_out), 64'h2B);
      check("pre_rst.fault", 64'(bus.shift_fault), 64'd1);
      #2 rst = 1'b1;
      #1 check_zero("async_rst");
      model_reset();
      bus.shiften = 2'b00;
      @(negedge clk);
      check_zero("rst_hold");
      rst = 1'b0;

      // Randomized phase
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < NCHAIN; c++)
            if ($urandom_range(5) == 0) bus.actred_raw[c] = ~bus.actred_raw[c];
         if ($urandom_range(63) == 0) bus.chain_en = NCHAIN'($urandom) | NCHAIN'($urandom);
         if ($urandom_range(15) == 0) bus.rxen_cfg = RW'($urandom);
         if ($urandom_range(31) == 0) bus.shiften  = NCHAIN'($urandom);
         bus.clr_stat = ($urandom_range(99) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
